// File: rtl/weight_loader_pkg.sv
// Shared definitions for the weight SRAM fill path: geometry, region map,
// loader state encoding and the running checksum helper.
package weight_loader_pkg;

    localparam int WGT_WORD_W         = 72;
    localparam int WGT_DEPTH          = 576;
    localparam int WGT_ADDR_W         = 10;
    localparam int WGT_BYTES_PER_WORD = 9;

    // Region base addresses inside the weight SRAM
    localparam logic [WGT_ADDR_W-1:0] WGT_CONV1_BASE   = 10'd0;
    localparam logic [WGT_ADDR_W-1:0] WGT_CONV2_BASE   = 10'd288;
    localparam logic [WGT_ADDR_W-1:0] WGT_CONV3_BASE   = 10'd352;
    localparam logic [WGT_ADDR_W-1:0] WGT_FC_W_BASE    = 10'd480;
    localparam logic [WGT_ADDR_W-1:0] WGT_FC_BIAS_BASE = 10'd544;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_LOAD  = 3'd1,
        ST_CHECK = 3'd2,
        ST_DONE  = 3'd3,
        ST_ERR   = 3'd4
    } wl_state_e;

    // Modulo-256 running sum used as the load checksum
    function automatic logic [7:0] csum_add(input logic [7:0] acc, input logic [7:0] b);
        return acc + b;
    endfunction

endpackage

// File: rtl/weight_loader_byte_packer.sv
// Packs accepted bytes little-endian into one wide word and presents the
// finished word, with a one-cycle valid, on the cycle after its last byte.
module weight_loader_byte_packer #(
    parameter int BYTES = 9
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 clr,
    input  logic                 byte_valid,
    input  logic [7:0]           byte_data,
    output logic                 last_byte,
    output logic                 word_valid,
    output logic [8*BYTES-1:0]   word
);

    localparam int              CNT_W    = $clog2(BYTES);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(BYTES - 1);

    logic [CNT_W-1:0]   byte_cnt_r;
    logic [8*BYTES-1:0] shift_r;
    logic [8*BYTES-1:0] word_r;
    logic               word_valid_r;

    assign last_byte  = (byte_cnt_r == LAST_CNT);
    assign word_valid = word_valid_r;
    assign word       = word_r;

    // Shift bytes in from the top so byte 0 ends in the low lane; latch the word on its last byte
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            byte_cnt_r   <= {CNT_W{1'b0}};
            shift_r      <= {(8*BYTES){1'b0}};
            word_r       <= {(8*BYTES){1'b0}};
            word_valid_r <= 1'b0;
        end else if (clr) begin
            byte_cnt_r   <= {CNT_W{1'b0}};
            shift_r      <= {(8*BYTES){1'b0}};
            word_valid_r <= 1'b0;
        end else begin
            word_valid_r <= 1'b0;
            if (byte_valid) begin
                shift_r <= {byte_data, shift_r[8*BYTES-1:8]};
                if (last_byte) begin
                    byte_cnt_r   <= {CNT_W{1'b0}};
                    word_r       <= {byte_data, shift_r[8*BYTES-1:8]};
                    word_valid_r <= 1'b1;
                end else begin
                    byte_cnt_r <= byte_cnt_r + CNT_W'(1);
                end
            end
        end
    end

endmodule

// File: rtl/weight_loader.sv
// Weight SRAM fill stage: streams host bytes into 72-bit SRAM words, verifies
// a trailing checksum byte and reports loaded (sta) or corrupted (err).
module weight_loader
    import weight_loader_pkg::*;
#(
    parameter int DEPTH          = WGT_DEPTH,
    parameter int BYTES_PER_WORD = WGT_BYTES_PER_WORD,
    parameter int ADDR_W         = WGT_ADDR_W
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        start,
    input  logic                        in_valid,
    input  logic [7:0]                  in_data,
    output logic                        in_ready,
    output logic                        write_en,
    output logic [ADDR_W-1:0]           addr_w,
    output logic [8*BYTES_PER_WORD-1:0] data_w,
    output logic                        sta,
    output logic                        err,
    output logic                        busy
);

    // One extra bit so the word counter never wraps after the final word
    localparam logic [ADDR_W:0] LAST_WORD = (ADDR_W+1)'(DEPTH - 1);

    wl_state_e          state_r;
    logic [ADDR_W:0]    word_cnt_r;
    logic [ADDR_W-1:0]  addr_w_r;
    logic [7:0]         sum_r;
    logic               sta_r;
    logic               err_r;
    logic               busy_r;

    logic               in_ready_s;
    logic               start_ok_s;
    logic               load_acc_s;
    logic               chk_acc_s;
    logic               last_byte_s;
    logic               word_valid_s;
    logic [8*BYTES_PER_WORD-1:0] word_s;

    // Decode host readiness from the current state
    always_comb begin
        in_ready_s = 1'b0;
        case (state_r)
            ST_LOAD, ST_CHECK: in_ready_s = 1'b1;
            default:           in_ready_s = 1'b0;
        endcase
    end

    assign start_ok_s = start && ((state_r == ST_IDLE) || (state_r == ST_DONE) || (state_r == ST_ERR));
    assign load_acc_s = in_valid && (state_r == ST_LOAD);
    assign chk_acc_s  = in_valid && (state_r == ST_CHECK);

    weight_loader_byte_packer #(
        .BYTES (BYTES_PER_WORD)
    ) u_packer (
        .clk        (clk),
        .rst_n      (rst_n),
        .clr        (start_ok_s),
        .byte_valid (load_acc_s),
        .byte_data  (in_data),
        .last_byte  (last_byte_s),
        .word_valid (word_valid_s),
        .word       (word_s)
    );

    // Load sequencing: address counting, checksum accumulation and status flags
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r    <= ST_IDLE;
            word_cnt_r <= {(ADDR_W+1){1'b0}};
            addr_w_r   <= {ADDR_W{1'b0}};
            sum_r      <= 8'd0;
            sta_r      <= 1'b0;
            err_r      <= 1'b0;
            busy_r     <= 1'b0;
        end else begin
            case (state_r)
                ST_IDLE, ST_DONE, ST_ERR: begin
                    if (start_ok_s) begin
                        state_r    <= ST_LOAD;
                        word_cnt_r <= {1'b0, WGT_CONV1_BASE};
                        sum_r      <= 8'd0;
                        sta_r      <= 1'b0;
                        err_r      <= 1'b0;
                        busy_r     <= 1'b1;
                    end else begin
                        busy_r <= 1'b0;
                    end
                end
                ST_LOAD: begin
                    if (load_acc_s) begin
                        sum_r <= csum_add(sum_r, in_data);
                        if (last_byte_s) begin
                            addr_w_r   <= word_cnt_r[ADDR_W-1:0];
                            word_cnt_r <= word_cnt_r + (ADDR_W+1)'(1);
                            if (word_cnt_r == LAST_WORD) begin
                                state_r <= ST_CHECK;
                            end else begin
                                state_r <= ST_LOAD;
                            end
                        end else begin
                            word_cnt_r <= word_cnt_r;
                        end
                    end else begin
                        sum_r <= sum_r;
                    end
                end
                ST_CHECK: begin
                    if (chk_acc_s) begin
                        busy_r <= 1'b0;
                        if (in_data == sum_r) begin
                            state_r <= ST_DONE;
                            sta_r   <= 1'b1;
                        end else begin
                            state_r <= ST_ERR;
                            err_r   <= 1'b1;
                        end
                    end else begin
                        busy_r <= 1'b1;
                    end
                end
                default: begin
                    state_r <= ST_IDLE;
                    busy_r  <= 1'b0;
                end
            endcase
        end
    end

    assign in_ready = in_ready_s;
    assign write_en = word_valid_s;
    assign data_w   = word_s;
    assign addr_w   = addr_w_r;
    assign sta      = sta_r;
    assign err      = err_r;
    assign busy     = busy_r;

endmodule

// File: tb/tb_weight_loader.sv
// Self-checking bench for weight_loader: a byte-level model predicts every
// SRAM write and the status levels; a per-cycle monitor compares the DUT.
module tb_weight_loader;

    localparam int NWORDS = 576;
    localparam int NBYTES = NWORDS * 9;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic        in_valid = 1'b0;
    logic [7:0]  in_data = 8'd0;
    logic        in_ready;
    logic        write_en;
    logic [9:0]  addr_w;
    logic [71:0] data_w;
    logic        sta;
    logic        err;
    logic        busy;

    int n_checks = 0;
    int n_fail   = 0;

    // model state
    bit          m_busy = 1'b0;
    bit          m_sta  = 1'b0;
    bit          m_err  = 1'b0;
    bit          chk_en = 1'b0;
    int          exp_addr_q[$];
    logic [71:0] exp_data_q[$];
    logic [71:0] cur_word;
    int          byte_k;
    int          word_idx;
    logic [7:0]  msum;
    int          writes_seen;
    logic [71:0] first_wr_data;
    logic [71:0] last_wr_data;

    weight_loader dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start),
        .in_valid (in_valid),
        .in_data  (in_data),
        .in_ready (in_ready),
        .write_en (write_en),
        .addr_w   (addr_w),
        .data_w   (data_w),
        .sta      (sta),
        .err      (err),
        .busy     (busy)
    );

    always #5 clk = ~clk;

    function automatic void chk(input string name, input logic [71:0] act, input logic [71:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endfunction

    // per-cycle monitor against the model
    always @(negedge clk) begin
        if (chk_en) begin
            chk("in_ready", in_ready, m_busy);
            chk("busy", busy, m_busy);
            chk("sta", sta, m_sta);
            chk("err", err, m_err);
            chk("sta_and_write_en", write_en && sta, 1'b0);
            if (write_en) begin
                if (exp_addr_q.size() == 0) begin
                    chk("unexpected_write", 1'b1, 1'b0);
                end else begin
                    chk("addr_w", addr_w, exp_addr_q.pop_front());
                    chk("data_w", data_w, exp_data_q.pop_front());
                    if (writes_seen == 0) first_wr_data = data_w;
                    last_wr_data = data_w;
                    writes_seen++;
                end
            end
        end
    end

    task automatic do_start();
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        m_busy = 1'b1; m_sta = 1'b0; m_err = 1'b0;
        byte_k = 0; word_idx = 0; msum = 8'd0; writes_seen = 0;
    endtask

    task automatic send_byte(input logic [7:0] b, input bit throttle, input bit is_data);
        int guard;
        if (throttle) begin
            while ($urandom_range(0, 1) == 0) begin
                in_valid = 1'b0;
                @(posedge clk); #1;
            end
        end
        in_valid = 1'b1;
        in_data  = b;
        guard = 0;
        while (!in_ready && guard < 50) begin
            @(posedge clk); #1;
            guard++;
        end
        if (!in_ready) chk("in_ready_timeout", 1'b0, 1'b1);
        @(posedge clk); #1;
        in_valid = 1'b0;
        if (is_data) begin
            cur_word[8*byte_k +: 8] = b;
            msum = msum + b;
            byte_k++;
            if (byte_k == 9) begin
                exp_addr_q.push_back(word_idx);
                exp_data_q.push_back(cur_word);
                word_idx++;
                byte_k = 0;
            end
        end
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        m_busy = 1'b0; m_sta = 1'b0; m_err = 1'b0;
        exp_addr_q.delete();
        exp_data_q.delete();
        #1;
        chk("rst_write_en", write_en, 1'b0);
        chk("rst_addr_w", addr_w, 10'd0);
        chk("rst_data_w", data_w, 72'd0);
        chk("rst_in_ready", in_ready, 1'b0);
        chk("rst_busy", busy, 1'b0);
        @(posedge clk); #1;
        rst_n = 1'b1;
    endtask

    task automatic run_load(input bit throttle, input bit bad_cs, input int pulse_byte, input int abort_byte);
        logic [7:0] cs;
        do_start();
        for (int i = 0; i < NBYTES; i++) begin
            if (i == abort_byte) begin
                do_reset();
                return;
            end
            if (i == pulse_byte) start = 1'b1;
            send_byte(8'(i % 251), throttle, 1'b1);
            start = 1'b0;
        end
        chk("model_sum", msum, 8'h62);
        cs = bad_cs ? (msum ^ 8'h01) : msum;
        send_byte(cs, 1'b0, 1'b0);
        m_busy = 1'b0;
        m_sta  = (cs == msum);
        m_err  = (cs != msum);
        @(negedge clk); #1;
        chk("sta_after_cs", sta, !bad_cs);
        chk("err_after_cs", err, bad_cs);
        repeat (3) @(posedge clk);
        #1;
        chk("write_count", writes_seen, NWORDS);
        chk("pending_writes", exp_addr_q.size(), 0);
        chk("word0_data", first_wr_data, 72'h080706050403020100);
        chk("word575_data", last_wr_data, 72'hA3A2A1A09F9E9D9C9B);
        chk("in_ready_after", in_ready, 1'b0);
    endtask

    initial begin
        // reset and idle, including a stray in_valid while idle
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        chk_en = 1'b1;
        in_valid = 1'b1;
        in_data  = 8'h5A;
        repeat (5) @(posedge clk);
        #1;
        in_valid = 1'b0;
        chk("idle_write_en", write_en, 1'b0);
        chk("idle_addr_w", addr_w, 10'd0);
        chk("idle_data_w", data_w, 72'd0);
        chk("idle_sta", sta, 1'b0);
        chk("idle_in_ready", in_ready, 1'b0);

        // full load with good checksum
        run_load(1'b0, 1'b0, -1, -1);

        // restart from DONE, with an ignored start pulse at word 100
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        chk("sta_drops_on_restart", sta, 1'b0);
        chk("busy_on_restart", busy, 1'b1);
        m_busy = 1'b1; m_sta = 1'b0; m_err = 1'b0;
        byte_k = 0; word_idx = 0; msum = 8'd0; writes_seen = 0;
        for (int i = 0; i < NBYTES; i++) begin
            if (i == 900) start = 1'b1;
            send_byte(8'(i % 251), 1'b0, 1'b1);
            start = 1'b0;
        end
        send_byte(msum, 1'b0, 1'b0);
        m_busy = 1'b0; m_sta = 1'b1; m_err = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("restart_write_count", writes_seen, NWORDS);
        chk("restart_sta", sta, 1'b1);

        // bad checksum
        run_load(1'b0, 1'b1, -1, -1);

        // throttled stream from ERR
        run_load(1'b1, 1'b0, -1, -1);

        // reset after word 300, then a clean load
        run_load(1'b0, 1'b0, -1, 301 * 9);
        repeat (2) @(posedge clk);
        #1;
        chk("post_abort_sta", sta, 1'b0);
        run_load(1'b0, 1'b0, -1, -1);

        chk_en = 1'b0;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
